mat_pow_22: RTL and testbench

MAT_POW_22 -- requirements
Module: mat_pow_22

---
 rtl/mat_pow_pkg.sv | 22 ++
 rtl/mat22_q15_mul.sv | 53 +++++
 rtl/mat_pow_22.sv | 149 ++++++++++++++
 tb/tb_mat_pow_22.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mat_pow_pkg.sv
// Shared types and constants for the 2x2 Q8.15 matrix power block.
package mat_pow_pkg;

    typedef logic signed [23:0] q815_t;
    // Element 0 is m11, then m12, m21, m22 (row-major).
    typedef q815_t [3:0] mat22_t;

    localparam int    Q_FRAC = 15;
    localparam q815_t Q_ONE  = 24'sd32768;
    localparam q815_t Q_MAX  = 24'sh7FFFFF;
    localparam q815_t Q_MIN  = 24'sh800000;

    localparam mat22_t Q_IDENT = {Q_ONE, 24'sd0, 24'sd0, Q_ONE};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/mat22_q15_mul.sv
// Combinational 2x2 Q8.15 matrix product p = a * b.
// MAT_POW_SAT_EN selects saturating rather than wrapping arithmetic.
module mat22_q15_mul
    import mat_pow_pkg::*;
(
    input  mat22_t a,
    input  mat22_t b,
    output mat22_t p
);

    // Full-precision product, floor shift back to Q8.15, then fit to 24 bits.
    function automatic q815_t q_mul(input q815_t x, input q815_t y);
        logic signed [47:0] xe;
        logic signed [47:0] ye;
        logic signed [47:0] s;
        xe = 48'(x);
        ye = 48'(y);
        s  = (xe * ye) >>> Q_FRAC;
`ifdef MAT_POW_SAT_EN
        if (s > 48'sd8388607) begin
            return Q_MAX;
        end else if (s < -48'sd8388608) begin
            return Q_MIN;
        end else begin
            return q815_t'(s);
        end
`else
        return q815_t'(s);
`endif
    endfunction

    function automatic q815_t q_add(input q815_t x, input q815_t y);
        logic signed [24:0] s;
        s = 25'(x) + 25'(y);
`ifdef MAT_POW_SAT_EN
        if (s > 25'sd8388607) begin
            return Q_MAX;
        end else if (s < -25'sd8388608) begin
            return Q_MIN;
        end else begin
            return q815_t'(s);
        end
`else
        return q815_t'(s);
`endif
    endfunction

    assign p[0] = q_add(q_mul(a[0], b[0]), q_mul(a[1], b[2]));
    assign p[1] = q_add(q_mul(a[0], b[1]), q_mul(a[1], b[3]));
    assign p[2] = q_add(q_mul(a[2], b[0]), q_mul(a[3], b[2]));
    assign p[3] = q_add(q_mul(a[2], b[1]), q_mul(a[3], b[3]));

endmodule

// File: rtl/mat_pow_22.sv
// Streams in a 2x2 Q8.15 matrix and exponent, computes M^N one multiply per
// clock and streams the result out. Overflow handling follows MAT_POW_SAT_EN.
module mat_pow_22 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic [3:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_last
);
    import mat_pow_pkg::*;

    state_t     state_r, state_s;
    mat22_t     m_r, m_s;
    mat22_t     r_r, r_s;
    mat22_t     prod_s;
    logic [3:0] n_r, n_s;
    logic [3:0] cnt_r, cnt_s;
    logic [1:0] load_idx_r, load_idx_s;
    logic [1:0] out_idx_r, out_idx_s;
    logic       in_ready_r, in_ready_s;
    logic       out_valid_r, out_valid_s;
    logic       out_last_r, out_last_s;
    q815_t      out_data_r, out_data_s;
    logic       in_fire_s;
    logic       out_fire_s;

    mat22_q15_mul u_mul (
        .a (r_r),
        .b (m_r),
        .p (prod_s)
    );

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;

    // Next-state, datapath register updates and registered output values.
    always_comb begin
        state_s    = state_r;
        m_s        = m_r;
        r_s        = r_r;
        n_s        = n_r;
        cnt_s      = cnt_r;
        load_idx_s = load_idx_r;
        out_idx_s  = out_idx_r;

        case (state_r)
            ST_IDLE: begin
                if (in_fire_s) begin
                    m_s[0]     = in_data;
                    n_s        = in_exp;
                    r_s        = Q_IDENT;
                    load_idx_s = 2'd1;
                    state_s    = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_fire_s) begin
                    m_s[load_idx_r] = in_data;
                    load_idx_s      = load_idx_r + 2'd1;
                    if (load_idx_r == 2'd3) begin
                        cnt_s     = 4'd0;
                        out_idx_s = 2'd0;
                        state_s   = (n_r != 4'd0) ? ST_COMPUTE : ST_OUT;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                r_s   = prod_s;
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == (n_r - 4'd1)) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_COMPUTE;
                end
            end
            ST_OUT: begin
                if (out_fire_s) begin
                    out_idx_s = out_idx_r + 2'd1;
                    if (out_idx_r == 2'd3) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_OUT;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        in_ready_s  = (state_s == ST_IDLE) || (state_s == ST_LOAD);
        out_valid_s = (state_s == ST_OUT);
        out_last_s  = (state_s == ST_OUT) && (out_idx_s == 2'd3);
        if (state_s == ST_OUT) begin
            out_data_s = r_s[out_idx_s];
        end else begin
            out_data_s = 24'sd0;
        end
    end

    // State, matrix, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            m_r         <= '0;
            r_r         <= Q_IDENT;
            n_r         <= 4'd0;
            cnt_r       <= 4'd0;
            load_idx_r  <= 2'd0;
            out_idx_r   <= 2'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 24'sd0;
        end else begin
            state_r     <= state_s;
            m_r         <= m_s;
            r_r         <= r_s;
            n_r         <= n_s;
            cnt_r       <= cnt_s;
            load_idx_r  <= load_idx_s;
            out_idx_r   <= out_idx_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
            out_data_r  <= out_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_mat_pow_22.sv
// Self-checking bench for mat_pow_22: directed cases plus random jobs against
// an integer matrix-power model. Honours MAT_POW_SAT_EN for expected values.
module tb_mat_pow_22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic [3:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;

    int     n_cmp = 0;
    int     n_err = 0;
    longint mm[4];
    longint got[4];

    always #5 clk = ~clk;

    mat_pow_22 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Reduce an exact integer into the 24-bit result range (wrap or clamp).
    function automatic longint fit24(input longint v);
        longint t;
`ifdef MAT_POW_SAT_EN
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
`else
        t = v % 64'sd16777216;
        if (t < 64'sd0) t = t + 64'sd16777216;
        if (t >= 64'sd8388608) t = t - 64'sd16777216;
        return t;
`endif
    endfunction

    function automatic longint term(input longint x, input longint y);
        return fit24((x * y) >>> 15);
    endfunction

    task automatic model_pow(input longint m[4], input int n, output longint r[4]);
        longint t[4];
        r = '{64'sd32768, 64'sd0, 64'sd0, 64'sd32768};
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    t[2*i+j] = fit24(term(r[2*i], m[j]) + term(r[2*i+1], m[2+j]));
                end
            end
            r = t;
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present four beats with optional idle gaps; returns at the negedge after beat 3.
    task automatic load_beats(input longint m[4], input int n, input int gap, input string tag);
        int cyc;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                in_valid = 1'b0;
                repeat (gap) step();
            end
            in_valid = 1'b1;
            in_data  = m[b][23:0];
            in_exp   = (b == 0) ? 4'(n) : 4'(~n);
            cyc = 0;
            while (!in_ready && cyc < 50) begin
                step();
                cyc++;
            end
            check({tag, " in_ready"}, longint'(in_ready), 64'sd1);
            step();
        end
        in_valid = 1'b1;
        in_data  = 24'hABCDEF;
    endtask

    task automatic run_job(input longint m[4], input int n, input int gap,
                           input int stall_beat, input int stall_len, input string tag);
        longint      exp_r[4];
        int          lat;
        int          cyc;
        logic [23:0] held;
        model_pow(m, n, exp_r);
        out_ready = 1'b1;
        load_beats(m, n, gap, tag);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, lat, n);
        check({tag, " busy in_ready"}, longint'(in_ready), 64'sd0);
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat && stall_len > 0) begin
                out_ready = 1'b0;
                held = out_data;
                repeat (stall_len) step();
                check({tag, " stall hold"}, longint'(out_data), longint'(held));
                check({tag, " stall valid"}, longint'(out_valid), 64'sd1);
                out_ready = 1'b1;
            end
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                step();
                cyc++;
            end
            got[b] = longint'($signed(out_data));
            check($sformatf("%s r%0d", tag, b), got[b], exp_r[b]);
            check($sformatf("%s last%0d", tag, b), longint'(out_last), (b == 3) ? 64'sd1 : 64'sd0);
            step();
        end
        check({tag, " done valid"}, longint'(out_valid), 64'sd0);
        check({tag, " done ready"}, longint'(in_ready), 64'sd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 24'd0;
        in_exp    = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst in_ready", longint'(in_ready), 64'sd0);
        check("rst out_valid", longint'(out_valid), 64'sd0);
        check("rst out_last", longint'(out_last), 64'sd0);
        check("rst out_data", longint'(out_data), 64'sd0);
        rst_n = 1'b1;
        step();
        check("post rst in_ready", longint'(in_ready), 64'sd1);

        mm = '{64'sd12345, -64'sd777, 64'sd4096, 64'sd99};
        run_job(mm, 0, 0, 4, 0, "identity");
        check("identity r11", got[0], 64'sd32768);
        check("identity r12", got[1], 64'sd0);

        mm = '{64'sd32768, 64'sd32768, 64'sd0, 64'sd32768};
        run_job(mm, 3, 0, 4, 0, "shear");
        check("shear r12", got[1], 64'sd98304);

        mm = '{-64'sd1, 64'sd0, 64'sd0, 64'sd16384};
        run_job(mm, 2, 0, 4, 0, "floor");
        check("floor r11", got[0], 64'sd0);
        check("floor r22", got[3], 64'sd8192);

        mm = '{-64'sd16384, 64'sd0, 64'sd0, 64'sd65536};
        run_job(mm, 2, 0, 4, 0, "sign");
        check("sign r11", got[0], 64'sd8192);
        check("sign r22", got[3], 64'sd131072);

        mm = '{64'sd4194304, 64'sd0, 64'sd0, 64'sd4194304};
        run_job(mm, 2, 0, 4, 0, "overflow");
`ifdef MAT_POW_SAT_EN
        check("overflow r11", got[0], 64'sd8388607);
`else
        check("overflow r11", got[0], 64'sd0);
`endif

        mm = '{64'sd30000, -64'sd20000, 64'sd15000, 64'sd40000};
        run_job(mm, 4, 2, 1, 3, "backpressure");

        mm = '{64'sd40000, 64'sd1000, -64'sd3000, 64'sd36000};
        out_ready = 1'b1;
        load_beats(mm, 15, 0, "reset");
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("reset out_valid", longint'(out_valid), 64'sd0);
        check("reset in_ready", longint'(in_ready), 64'sd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after reset in_ready", longint'(in_ready), 64'sd1);
        check("after reset out_valid", longint'(out_valid), 64'sd0);
        mm = '{64'sd123456, -64'sd65432, 64'sd7, -64'sd8388608};
        run_job(mm, 1, 0, 4, 0, "n1");
        check("n1 exact r22", got[3], -64'sd8388608);

        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) begin
                mm[i] = longint'($urandom_range(0, 131071)) - 64'sd65536;
            end
            run_job(mm, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
